mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: instruction-fetch and data-memory requester ports,
// the single shared memory port and the two pipeline stall requests.
interface mem_arbiter_if;
    // instruction-fetch requester (read only)
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    // data-memory requester
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    // shared memory port
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // pipeline stall requests
    logic        stallF;
    logic        stallM;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stallF, stallM
    );

    // Environment side: requesters plus the memory.
    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stallF, stallM
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IF/DM) round-robin arbiter onto one fixed-latency memory port.
// One transaction at a time: IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE -> IDLE.
module mem_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t      state_q, state_d;
    gnt_t        gnt_q, gnt_d;
    gnt_t        lg_q, lg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    logic        any_req;
    logic        pick_dm;
    logic        capture;
    logic [1:0]  ready_vec;
    logic [1:0][31:0] rdata_vec;

    always_comb begin
        any_req = bus.if_req | bus.dm_req;
        // On a conflict the port that did not win last time goes next.
        pick_dm = bus.dm_req & (~bus.if_req | (lg_q == GNT_IF));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_IF;
            lg_q    <= GNT_IF;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Next-state logic; requester inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        lg_d    = lg_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                    if (pick_dm) begin
                        gnt_d   = GNT_DM;
                        addr_d  = bus.dm_addr;
                        we_d    = bus.dm_we;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        gnt_d   = GNT_IF;
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                lg_d    = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        capture    = 1'b0;
        ready_vec  = '0;
        case (state_q)
            ST_ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
            end
            ST_WAIT:  capture = (cnt_q == '0) & ~we_q;
            ST_DONE:  ready_vec[gnt_q] = 1'b1;
            default: ;
        endcase
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_ready  = ready_vec[0];
        bus.dm_ready  = ready_vec[1];
        bus.if_rdata  = rdata_vec[0];
        bus.dm_rdata  = rdata_vec[1];
        bus.stallF    = bus.if_req & ~ready_vec[0];
        bus.stallM    = bus.dm_req & ~ready_vec[1];
    end

    // Per-port read-data holding registers (0 = IF, 1 = DM); writes leave them alone.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [31:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (capture && (gnt_q == ((gi == 1) ? GNT_DM : GNT_IF))) begin
                rdata_d = bus.mem_rdata;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_vec[gi] = rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (LAT 2, 1, 15) share one set of
// requester inputs, each with a latency-accurate memory model of its own.
module tb_mem_arbiter;
    localparam int NDUT   = 3;
    localparam int MAXLAT = 15;
    localparam int NVEC   = 9;

    function automatic int lat_of(input int i);
        case (i)
            0:       lat_of = 2;
            1:       lat_of = 1;
            default: lat_of = 15;
        endcase
    endfunction

    typedef struct {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mdata;
        logic        exp_dm;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_data;

    logic [NDUT-1:0]       o_en, o_we, o_ifr, o_dmr, o_stf, o_stm;
    logic [NDUT-1:0][31:0] o_addr, o_wdata, o_ifd, o_dmd;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];
    int   ev [NDUT][8];
    int   nev [NDUT];
    int   first_g [NDUT];
    int   exp_ev [8];
    int   e;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int L = lat_of(gi);
        mem_arbiter_if bus_i ();
        logic [15:0] rd_sr = '0;

        mem_arbiter #(.LAT(L)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_i)
        );

        assign bus_i.if_req   = if_req;
        assign bus_i.if_addr  = if_addr;
        assign bus_i.dm_req   = dm_req;
        assign bus_i.dm_we    = dm_we;
        assign bus_i.dm_addr  = dm_addr;
        assign bus_i.dm_wdata = dm_wdata;

        // Read data valid only in the cycle L after the issue cycle.
        always @(posedge clk) rd_sr <= {rd_sr[14:0], bus_i.mem_en & ~bus_i.mem_we};
        assign bus_i.mem_rdata = rd_sr[L-1] ? mem_data : 32'hBAD0_BAD0;

        assign o_en[gi]    = bus_i.mem_en;
        assign o_we[gi]    = bus_i.mem_we;
        assign o_ifr[gi]   = bus_i.if_ready;
        assign o_dmr[gi]   = bus_i.dm_ready;
        assign o_stf[gi]   = bus_i.stallF;
        assign o_stm[gi]   = bus_i.stallM;
        assign o_addr[gi]  = bus_i.mem_addr;
        assign o_wdata[gi] = bus_i.mem_wdata;
        assign o_ifd[gi]   = bus_i.if_rdata;
        assign o_dmd[gi]   = bus_i.dm_rdata;
    end

    task automatic chk1(input string nm, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d(LAT=%0d): got %b want %b", nm, i, lat_of(i), act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d(LAT=%0d): got %h want %h", nm, i, lat_of(i), act, exp);
        end
    endtask

    // Starts at a negedge with every instance in IDLE, ends at a negedge with every instance in IDLE.
    task automatic run_vec(input int n, input vec_t v);
        logic [31:0] exp_addr;
        int l;
        if_req   = v.if_req;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        if_addr  = v.if_addr;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        mem_data = v.mdata;
        exp_addr = v.exp_dm ? v.dm_addr : v.if_addr;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk1("stallF_pre", i, o_stf[i], v.if_req);
            chk1("stallM_pre", i, o_stm[i], v.dm_req);
        end
        @(posedge clk);
        #1;
        // Drop requests and scramble inputs right after the grant edge: must not matter.
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = ~dm_we;
        if_addr  = ~if_addr;
        dm_addr  = ~dm_addr;
        dm_wdata = ~dm_wdata;
        for (int k = 1; k <= MAXLAT + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                l = lat_of(i);
                chk1("mem_en", i, o_en[i], k == 1);
                chk1("mem_we", i, o_we[i], (k == 1) && v.exp_dm && v.dm_we);
                if (k == 1) chk32("mem_addr", i, o_addr[i], exp_addr);
                if (k == 1 && v.exp_dm && v.dm_we) chk32("mem_wdata", i, o_wdata[i], v.dm_wdata);
                chk1("if_ready", i, o_ifr[i], (k == l + 2) && !v.exp_dm);
                chk1("dm_ready", i, o_dmr[i], (k == l + 2) && v.exp_dm);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk32("if_rdata", i, o_ifd[i], v.exp_if_rdata);
            chk32("dm_rdata", i, o_dmd[i], v.exp_dm_rdata);
        end
        $display("vec %0d: %s %s addr=%h if_rdata=%h dm_rdata=%h", n, v.exp_dm ? "DM" : "IF",
                 (v.exp_dm && v.dm_we) ? "write" : "read", exp_addr, o_ifd[0], o_dmd[0]);
    endtask

    initial begin
        reset    = 1'b0;
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        mem_data = '0;
        exp_ev   = '{2, 4, 1, 3, 2, 4, 1, 3};

        //          ifq   dmq   we    if_addr       dm_addr       dm_wdata      mdata         dm?   exp_if_rdata  exp_dm_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        32'h2002_0005, 1'b0, 32'h2002_0005, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'd84,       32'd4859,     32'h1234_5678, 1'b1, 32'h2002_0005, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0200, 32'h0,        32'hCAFE_0001, 1'b1, 32'h2002_0005, 32'hCAFE_0001};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, 32'h0,        32'h1111_2222, 1'b0, 32'h1111_2222, 32'hCAFE_0001};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0600, 32'hA5A5_5A5A, 32'h9999_9999, 1'b1, 32'h1111_2222, 32'hCAFE_0001};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0800, 32'h0,        32'h3333_4444, 1'b0, 32'h3333_4444, 32'hCAFE_0001};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0900, 32'h0000_0001, 32'h0,        1'b1, 32'h3333_4444, 32'hCAFE_0001};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0000_0B00, 32'h0,        32'h5555_6666, 1'b0, 32'h5555_6666, 32'hCAFE_0001};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0000_0D00, 32'h0000_0C00, 32'h0,        32'h7777_8888, 1'b1, 32'h5555_6666, 32'h7777_8888};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk1("rst_mem_en", i, o_en[i], 1'b0);
            chk1("rst_mem_we", i, o_we[i], 1'b0);
            chk1("rst_if_ready", i, o_ifr[i], 1'b0);
            chk1("rst_dm_ready", i, o_dmr[i], 1'b0);
            chk32("rst_if_rdata", i, o_ifd[i], 32'h0);
            chk32("rst_dm_rdata", i, o_dmd[i], 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int n = 0; n < NVEC; n++) run_vec(n, vecs[n]);

        // Reset during WAIT of a DM read: aborted, no ready, read data cleared.
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h0000_1234;
        mem_data = 32'hFEED_0000;
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk1("abort_issue_en", i, o_en[i], 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            reset = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                chk1("abort_mem_en", i, o_en[i], 1'b0);
                chk1("abort_dm_ready", i, o_dmr[i], 1'b0);
                chk1("abort_if_ready", i, o_ifr[i], 1'b0);
                chk32("abort_dm_rdata", i, o_dmd[i], 32'h0);
            end
        end
        $display("abort: dm read reset in WAIT, dm_rdata=%h", o_dmd[0]);

        // Both requests held from reset: no grant while reset low, then DM, IF, DM, IF.
        reset   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        if_addr = 32'h0000_0100;
        dm_addr = 32'h0000_0200;
        mem_data = 32'h600D_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) chk1("rst_low_mem_en", i, o_en[i], 1'b0);
        end
        for (int i = 0; i < NDUT; i++) begin
            nev[i]     = 0;
            first_g[i] = 0;
            for (int j = 0; j < 8; j++) ev[i][j] = 0;
        end
        reset = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                e = 0;
                if (o_en[i]) e = (o_addr[i] == 32'h0000_0200) ? 2 : 1;
                else if (o_ifr[i]) e = 3;
                else if (o_dmr[i]) e = 4;
                if (e != 0 && nev[i] < 8) begin
                    ev[i][nev[i]] = e;
                    nev[i]++;
                end
                if (o_en[i] && first_g[i] == 0) first_g[i] = c;
                chk1("stallF_hold", i, o_stf[i], !o_ifr[i]);
                chk1("stallM_hold", i, o_stm[i], !o_dmr[i]);
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            chk32("first_grant_cycle", i, 32'(first_g[i]), 32'd1);
            for (int j = 0; j < 8; j++) chk32("rr_event", i, 32'(ev[i][j]), 32'(exp_ev[j]));
        end
        $display("round-robin: events dut0 %0d %0d %0d %0d %0d %0d %0d %0d",
                 ev[0][0], ev[0][1], ev[0][2], ev[0][3], ev[0][4], ev[0][5], ev[0][6], ev[0][7]);
        if_req = 1'b0;
        dm_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
